// File: rtl/mem_pkg.sv
// mem_pkg: shared line geometry, FSM state encoding and port ids for the
// main-memory responder (mem_ctrl) and its arbiter.
package mem_pkg;

    localparam int LINE_W         = 128;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_BITS    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: picks which cache port is granted when mem_ctrl is idle.
// Default build: fixed dcache priority. With MEM_RR_EN defined, a tie goes to
// the port that was not served last, tracked by a last-served register.
module mem_arbiter
    import mem_pkg::*;
(
`ifdef MEM_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic take,
`endif
    input  logic i_req,
    input  logic d_req,
    output logic grant
);

`ifdef MEM_RR_EN
    logic last_q;

    // Remember which port was granted most recently; starts as icache-last
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= PORT_I;
        end else if (take) begin
            last_q <= grant;
        end
    end

    // On a tie favour the port not served last, otherwise whoever is asking
    always_comb begin
        grant = PORT_I;
        if (i_req && d_req) begin
            grant = (last_q == PORT_I) ? PORT_D : PORT_I;
        end else if (d_req) begin
            grant = PORT_D;
        end
    end
`else
    logic unused_i_req;
    assign unused_i_req = i_req;

    // Dcache always wins; icache is granted only when dcache is quiet
    always_comb begin
        grant = PORT_I;
        if (d_req) begin
            grant = PORT_D;
        end
    end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: main-memory responder for the icache and dcache miss ports.
// Grants one request from IDLE, waits LATENCY edges in BUSY, performs the
// line access and then holds the ack in RESP until the requester drops req.
// Optional macro MEM_RR_EN switches the arbiter to round-robin on ties.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int LATENCY     = 5,
    parameter int DEPTH_WORDS = 4096,
    parameter int LINE_W      = mem_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ack,
    output logic [LINE_W-1:0] i_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [LINE_W-1:0] d_rdata,
    output logic              busy
);

    localparam int LINES = DEPTH_WORDS / WORDS_PER_LINE;
    localparam int IDX_W = $clog2(LINES);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               port_q;
    logic [IDX_W-1:0]   idx_q;
    logic               we_q;
    logic [LINE_W-1:0]  wdata_q;
    logic               grant;
    logic               take;
    logic               access;
    logic               granted_req;
    logic [LINE_W-1:0]  rd_line;
    logic [IDX_W-1:0]   i_idx, d_idx;
    logic [31:0]        mem [DEPTH_WORDS];
    logic               unused_addr_bits;

    // Line indices drop the byte offset and alias modulo the array size
    assign i_idx = i_addr[IDX_W+OFFSET_BITS-1:OFFSET_BITS];
    assign d_idx = d_addr[IDX_W+OFFSET_BITS-1:OFFSET_BITS];
    assign unused_addr_bits = ^{i_addr[31:IDX_W+OFFSET_BITS], i_addr[OFFSET_BITS-1:0],
                                d_addr[31:IDX_W+OFFSET_BITS], d_addr[OFFSET_BITS-1:0]};

    mem_arbiter u_arbiter (
`ifdef MEM_RR_EN
        .clk   (clk),
        .reset (reset),
        .take  (take),
`endif
        .i_req (i_req),
        .d_req (d_req),
        .grant (grant)
    );

    assign granted_req = (port_q == PORT_D) ? d_req : i_req;
    assign i_ack       = (state_q == RESP) && (port_q == PORT_I);
    assign d_ack       = (state_q == RESP) && (port_q == PORT_D);
    assign busy        = (state_q != IDLE);

    // Next-state logic: grant from IDLE, count down in BUSY, wait for req drop in RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    take    = 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (!granted_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus the request details captured at grant time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            port_q  <= PORT_I;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                port_q  <= grant;
                idx_q   <= (grant == PORT_D) ? d_idx : i_idx;
                we_q    <= (grant == PORT_D) && d_we;
                wdata_q <= d_wdata;
            end
        end
    end

    // Gather the four words of the latched line into one read line
    always_comb begin
        rd_line = '0;
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            rd_line[32*k +: 32] = mem[{idx_q, k[1:0]}];
        end
    end

    // Storage commits a write-back on the access edge; never cleared by reset
    always_ff @(posedge clk) begin
        if (access && we_q) begin
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
                mem[{idx_q, k[1:0]}] <= wdata_q[32*k +: 32];
            end
        end
    end

    // Data outputs update only on the access edge and otherwise hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_data  <= '0;
            d_rdata <= '0;
        end else if (access) begin
            if (we_q) begin
                d_rdata <= wdata_q;
            end else if (port_q == PORT_D) begin
                d_rdata <= rd_line;
            end else begin
                i_data <= rd_line;
            end
        end
    end

endmodule
